// File: rtl/sb_msg_pkg.sv
// Shared constants, message table and packet builder for the sideband
// message-without-data transmitter.
package sb_msg_pkg;

  localparam int SB_MSG_WIDTH = 4;
  localparam int PKT_WIDTH    = 64;

  localparam logic [SB_MSG_WIDTH-1:0] MSG_CAL_DONE_REQ  = 4'd1;
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CAL_DONE_RESP = 4'd2;

  localparam logic [4:0] OPCODE_MSG_NO_DATA = 5'b10010;

  localparam int OPCODE_LSB  = 0;
  localparam int MSGCODE_LSB = 14;
  localparam int SRCID_LSB   = 29;
  localparam int SUBCODE_LSB = 32;
  localparam int DSTID_LSB   = 56;
  localparam int CP_BIT      = 62;
  localparam int DP_BIT      = 63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic       known;
    logic [7:0] msg_code;
    logic [7:0] msg_subcode;
  } msg_info_t;

  // New messages are added here; anything absent is reported as unknown.
  function automatic msg_info_t lookup_msg(input logic [SB_MSG_WIDTH-1:0] id);
    msg_info_t info;
    info = '0;
    case (id)
      MSG_CAL_DONE_REQ:  info = '{known: 1'b1, msg_code: 8'hA5, msg_subcode: 8'h02};
      MSG_CAL_DONE_RESP: info = '{known: 1'b1, msg_code: 8'hAA, msg_subcode: 8'h02};
      default:           info = '0;
    endcase
    return info;
  endfunction

  function automatic logic [PKT_WIDTH-1:0] build_pkt(input logic [7:0] msg_code,
                                                     input logic [7:0] msg_subcode,
                                                     input logic [2:0] srcid,
                                                     input logic [2:0] dstid);
    logic [PKT_WIDTH-1:0] pkt;
    pkt = '0;
    pkt[OPCODE_LSB  +: 5] = OPCODE_MSG_NO_DATA;
    pkt[MSGCODE_LSB +: 8] = msg_code;
    pkt[SRCID_LSB   +: 3] = srcid;
    pkt[SUBCODE_LSB +: 8] = msg_subcode;
    pkt[DSTID_LSB   +: 3] = dstid;
    pkt[CP_BIT]           = ^pkt[CP_BIT-1:0];
    pkt[DP_BIT]           = 1'b0;
    return pkt;
  endfunction

endpackage

// File: rtl/sb_msg_tx_serializer_if.sv
// Request/status bundle between LTSM sub-state logic and the sideband transmitter.
// Handshake: the requester holds i_msg_valid_tx and i_TX_SbMessage as a level until it
// sees o_falling_edge_busy; the ID is captured on acceptance and later changes are ignored.
interface sb_msg_tx_serializer_if;
  import sb_msg_pkg::*;

  logic [SB_MSG_WIDTH-1:0] i_TX_SbMessage;
  logic                    i_msg_valid_tx;
  logic                    o_TXDATASB;
  logic                    o_TXCKSB_en;
  logic                    o_busy;
  logic                    o_falling_edge_busy;
  logic                    o_unknown_msg;

  modport master (
    output i_TX_SbMessage, i_msg_valid_tx,
    input  o_TXDATASB, o_TXCKSB_en, o_busy, o_falling_edge_busy, o_unknown_msg
  );

  modport slave (
    input  i_TX_SbMessage, i_msg_valid_tx,
    output o_TXDATASB, o_TXCKSB_en, o_busy, o_falling_edge_busy, o_unknown_msg
  );
endinterface

// File: rtl/sb_pkt_shifter.sv
// Parallel-load shift register emitting a packet LSB-first, one bit per cycle,
// with a done strobe on the cycle the last bit is on the line.
module sb_pkt_shifter #(
  parameter int PKT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PKT_WIDTH-1:0] pkt,
  output logic                 ser_data,
  output logic                 active,
  output logic                 done
);
  localparam int CW = $clog2(PKT_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(PKT_WIDTH - 1);

  logic [PKT_WIDTH-1:0] sreg;
  logic [CW-1:0]        bit_cnt;

  // Shifting on the final bit as well leaves the register zeroed afterwards,
  // so the line idles low without extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (load) begin
      sreg    <= pkt;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      sreg <= sreg >> 1;
      if (bit_cnt == LAST_BIT) begin
        active  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign ser_data = sreg[0];
  assign done     = active && (bit_cnt == LAST_BIT);
endmodule

// File: rtl/sb_msg_tx_serializer.sv
// Sideband message transmitter: accepts an encoded message ID, sends the 64-bit
// packet serially, then holds busy through the idle gap and pulses on busy release.
module sb_msg_tx_serializer
  import sb_msg_pkg::*;
#(
  parameter int         GAP_CYCLES = 32,
  parameter logic [2:0] SRCID      = 3'b010,
  parameter logic [2:0] DSTID      = 3'b110
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  sb_msg_tx_serializer_if.slave    bus,
  output tx_state_t                dbg_state
);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_t            state;
  logic [GW-1:0]        gap_cnt;
  logic                 busy_q;
  logic                 fe_q;
  logic                 unknown_q;
  msg_info_t            info;
  logic                 accept;
  logic [PKT_WIDTH-1:0] pkt;
  logic                 ser_data;
  logic                 sh_active;
  logic                 sh_done;

  assign info = lookup_msg(bus.i_TX_SbMessage);
  assign pkt  = build_pkt(info.msg_code, info.msg_subcode, SRCID, DSTID);

  // The pulse cycle blocks acceptance so a requester still holding valid
  // while reacting to the pulse does not get a duplicate packet.
  assign accept = (state == ST_IDLE) && bus.i_msg_valid_tx && info.known && !fe_q;

  sb_pkt_shifter #(.PKT_WIDTH(PKT_WIDTH)) u_shifter (
    .clk      (CLK),
    .rst_n    (rst_n),
    .load     (accept),
    .pkt      (pkt),
    .ser_data (ser_data),
    .active   (sh_active),
    .done     (sh_done)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      busy_q    <= 1'b0;
      fe_q      <= 1'b0;
      unknown_q <= 1'b0;
    end else begin
      fe_q      <= 1'b0;
      unknown_q <= (state == ST_IDLE) && bus.i_msg_valid_tx && !info.known;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_SHIFT;
            busy_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_TXDATASB          = ser_data;
  assign bus.o_TXCKSB_en         = sh_active;
  assign bus.o_busy              = busy_q;
  assign bus.o_falling_edge_busy = fe_q;
  assign bus.o_unknown_msg       = unknown_q;
  assign dbg_state               = state;
endmodule

// File: tb/tb_sb_msg_tx_serializer.sv
// Directed bench for the sideband message transmitter: packet contents, timing,
// holdoff, unknown IDs and mid-packet reset.
module tb_sb_msg_tx_serializer;
  import sb_msg_pkg::*;

  localparam logic [63:0] REQ_PKT  = 64'h0600_0002_4029_4012;
  localparam logic [63:0] RESP_PKT = 64'h0600_0002_402A_8012;

  logic      clk;
  logic      rst_n;
  tx_state_t dbg_state;
  int        total = 0;
  int        bad   = 0;

  sb_msg_tx_serializer_if bus ();

  sb_msg_tx_serializer dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.o_TXDATASB, bus.o_TXCKSB_en, bus.o_busy,
            bus.o_falling_edge_busy, bus.o_unknown_msg};
  endfunction

  // Called at the negedge of the acceptance cycle; returns at the negedge of
  // the pulse cycle after applying the requested post-pulse inputs.
  task automatic rx_packet(input string tag, input logic [63:0] exp,
                           input logic valid_after, input logic [3:0] id_after,
                           input int change_bit, input logic [3:0] change_id);
    logic [63:0] rx;
    int ck, bz, fe, junk;
    rx = '0; ck = 0; bz = 0; fe = 0; junk = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rx[i] = bus.o_TXDATASB;
      ck += int'(bus.o_TXCKSB_en);
      bz += int'(bus.o_busy);
      fe += int'(bus.o_falling_edge_busy);
      if (i == change_bit) bus.i_TX_SbMessage = change_id;
    end
    chk({tag, "_data"}, rx, exp);
    chk({tag, "_cken_cnt"}, 64'(ck), 64'd64);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      junk += int'(bus.o_TXDATASB | bus.o_TXCKSB_en);
      bz   += int'(bus.o_busy);
      fe   += int'(bus.o_falling_edge_busy);
    end
    chk({tag, "_gap_quiet"}, 64'(junk), 64'd0);
    chk({tag, "_busy_cnt"}, 64'(bz), 64'd96);
    chk({tag, "_early_pulse"}, 64'(fe), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse_busy"}, 64'(bus.o_busy), 64'd0);
    chk({tag, "_pulse"}, 64'(bus.o_falling_edge_busy), 64'd1);
    bus.i_msg_valid_tx = valid_after;
    bus.i_TX_SbMessage = id_after;
  endtask

  initial begin
    int bz;
    rst_n = 1'b0;
    bus.i_msg_valid_tx = 1'b0;
    bus.i_TX_SbMessage = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outs", 64'(outs()), 64'd0);

    // Single REQ.
    bus.i_msg_valid_tx = 1'b1;
    bus.i_TX_SbMessage = MSG_CAL_DONE_REQ;
    rx_packet("req", REQ_PKT, 1'b0, 4'd0, -1, 4'd0);
    @(negedge clk);
    chk("req_pulse_single", 64'(bus.o_falling_edge_busy), 64'd0);

    // RESP with valid still high during the pulse cycle: must not resend.
    bus.i_msg_valid_tx = 1'b1;
    bus.i_TX_SbMessage = MSG_CAL_DONE_RESP;
    rx_packet("resp", RESP_PKT, 1'b1, MSG_CAL_DONE_RESP, -1, 4'd0);
    @(negedge clk);
    bus.i_msg_valid_tx = 1'b0;
    bz = int'(bus.o_busy) + int'(bus.o_TXCKSB_en);
    repeat (4) begin
      @(negedge clk);
      bz += int'(bus.o_busy) + int'(bus.o_TXCKSB_en);
    end
    chk("holdoff_no_resend", 64'(bz), 64'd0);

    // Unknown IDs.
    bus.i_msg_valid_tx = 1'b1;
    bus.i_TX_SbMessage = 4'd0;
    @(negedge clk);
    chk("unk0_outs", 64'(outs()), 64'b00001);
    bus.i_TX_SbMessage = 4'd7;
    @(negedge clk);
    chk("unk7_outs", 64'(outs()), 64'b00001);
    bus.i_msg_valid_tx = 1'b0;
    @(negedge clk);
    chk("unk_clear", 64'(outs()), 64'd0);
    chk("unk_state", 64'(dbg_state), 64'(ST_IDLE));

    // Reset while bit 20 of a REQ is on the line.
    bus.i_msg_valid_tx = 1'b1;
    bus.i_TX_SbMessage = MSG_CAL_DONE_REQ;
    repeat (21) @(negedge clk);
    chk("bit20_value", 64'(bus.o_TXDATASB), 64'(REQ_PKT[20]));
    chk("bit20_busy", 64'(bus.o_busy), 64'd1);
    bus.i_msg_valid_tx = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", 64'(outs()), 64'd0);
    chk("async_reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_exit_outs", 64'(outs()), 64'd0);

    // Fresh REQ after reset, with the ID changed to RESP mid-shift.
    bus.i_msg_valid_tx = 1'b1;
    bus.i_TX_SbMessage = MSG_CAL_DONE_REQ;
    rx_packet("req_midchg", REQ_PKT, 1'b0, 4'd0, 10, MSG_CAL_DONE_RESP);

    // Back-to-back: re-raise with RESP one cycle after the pulse.
    @(negedge clk);
    chk("b2b_gap_idle", 64'(bus.o_busy), 64'd0);
    bus.i_msg_valid_tx = 1'b1;
    bus.i_TX_SbMessage = MSG_CAL_DONE_RESP;
    rx_packet("b2b_resp", RESP_PKT, 1'b0, 4'd0, -1, 4'd0);
    @(negedge clk);
    chk("final_outs", 64'(outs()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
